// File: rtl/servo_pkg.sv
// Shared definitions for the servo position sequencer.
//   - Default position width, neutral position and upper clamp.
//   - 3-bit state codes, matching the db_estado encoding used by the game control unit.
//   - Helper that classifies the states reported on the busy output.
package servo_pkg;

    localparam int unsigned SERVO_POS_W   = 10;
    localparam int unsigned SERVO_POS_MAX = 1023;
    localparam int unsigned SERVO_CENTRO  = 512;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCalib  = 3'd1,
        StRamp   = 3'd2,
        StSettle = 3'd3,
        StDone   = 3'd4,
        StJogo   = 3'd5,
        StTrava  = 3'd6
    } servo_state_e;

    function automatic logic state_is_busy(input servo_state_e s);
        return (s == StCalib) || (s == StRamp) || (s == StSettle);
    endfunction

endpackage

// File: rtl/servo_step_tick.sv
// Step prescaler for slew-limited ramps.
//   clock, reset_n : clock and asynchronous active-low reset
//   en             : count while high; the count is held at zero otherwise
//   clr            : synchronous clear, wins over en
//   tick           : high for one cycle when the count wraps at STEP_DIV-1,
//                    so the first tick comes STEP_DIV cycles after a clear
module servo_step_tick #(
    parameter int unsigned STEP_DIV = 1000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(STEP_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/servo_seq.sv
// Servo position sequencer / arbiter between the game control unit and the PWM generator.
// Owns servo_pos and grants it by priority: calibration, lock, prep ramp, gameplay.
//   clock, reset_n  : clock and asynchronous active-low reset
//   calib_start     : level, calibration request (preempts from any other state)
//   sensorFimCurso  : level, end-stop switch (already synchronised)
//   trava_servo     : level, freeze servo
//   prep_req        : level, only its rising edge is used
//   jogo_ativo      : level, gameplay active
//   jogo_pos        : gameplay target position
//   servo_pos       : registered position to the PWM generator
//   prep_done       : one-cycle pulse after ramp to CENTRO and settle delay
//   calib_done      : one-cycle pulse when the end-stop is reached
//   busy            : registered, high in CALIB/RAMP/SETTLE
//   db_estado       : current state code (combinational from the state register)
module servo_seq
    import servo_pkg::*;
#(
    parameter int unsigned POS_W      = SERVO_POS_W,
    parameter int unsigned POS_MAX    = SERVO_POS_MAX,
    parameter int unsigned CENTRO     = SERVO_CENTRO,
    parameter int unsigned STEP_DIV   = 1000,
    parameter int unsigned SETTLE_CYC = 50000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             calib_start,
    input  logic             sensorFimCurso,
    input  logic             trava_servo,
    input  logic             prep_req,
    input  logic             jogo_ativo,
    input  logic [POS_W-1:0] jogo_pos,
    output logic [POS_W-1:0] servo_pos,
    output logic             prep_done,
    output logic             calib_done,
    output logic             busy,
    output logic [2:0]       db_estado
);

    localparam logic [POS_W-1:0] CentroPos = POS_W'(CENTRO);
    localparam logic [POS_W-1:0] MaxPos    = POS_W'(POS_MAX);
    localparam int unsigned      SetW      = $clog2(SETTLE_CYC + 1);
    localparam logic [SetW-1:0]  SetLast   = SetW'(SETTLE_CYC - 1);

    servo_state_e     state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [SetW-1:0]  settle_q, settle_d;
    logic             prep_pend_q, prep_pend_d;
    logic             prep_req_q;
    logic             prep_done_q, calib_done_q, busy_q;
    logic             calib_done_d;
    logic             prep_edge;
    logic             preempt;
    logic             step_tick;

    assign prep_edge = prep_req && !prep_req_q;
    assign preempt   = calib_start && (state_q != StCalib);

    servo_step_tick #(
        .STEP_DIV (STEP_DIV)
    ) u_step_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .en      ((state_q == StCalib) || (state_q == StRamp)),
        .clr     (state_d != state_q),
        .tick    (step_tick)
    );

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        settle_d     = settle_q;
        calib_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (calib_start) begin
                    state_d = StCalib;
                end else if (trava_servo) begin
                    state_d = StTrava;
                end else if (prep_pend_q || prep_edge) begin
                    state_d = StRamp;
                end else if (jogo_ativo) begin
                    state_d = StJogo;
                end
            end
            StCalib: begin
                // End-stop wins over a step landing in the same cycle.
                if (sensorFimCurso) begin
                    pos_d        = '0;
                    calib_done_d = 1'b1;
                    state_d      = StIdle;
                end else if (step_tick && (pos_q != '0)) begin
                    pos_d = pos_q - POS_W'(1);
                end
            end
            StTrava: begin
                if (!trava_servo) begin
                    state_d = StIdle;
                end
            end
            StRamp: begin
                if (pos_q == CentroPos) begin
                    state_d  = StSettle;
                    settle_d = '0;
                end else if (step_tick) begin
                    pos_d = (pos_q < CentroPos) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                end
            end
            StSettle: begin
                if (settle_q == SetLast) begin
                    state_d = StDone;
                end else begin
                    settle_d = settle_q + SetW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StJogo: begin
                if (!jogo_ativo) begin
                    state_d = StIdle;
                end else begin
                    pos_d = (jogo_pos > MaxPos) ? MaxPos : jogo_pos;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Calibration preempts everything and leaves the position where it is.
        if (preempt) begin
            state_d = StCalib;
            pos_d   = pos_q;
        end
    end

    always_comb begin
        prep_pend_d = prep_pend_q;
        if (preempt) begin
            prep_pend_d = 1'b0;
        end else if ((state_d == StRamp) && (state_q != StRamp)) begin
            prep_pend_d = 1'b0;
        end else if (prep_edge && (state_q != StRamp) && (state_q != StSettle)
                     && (state_q != StDone)) begin
            prep_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            pos_q        <= CentroPos;
            settle_q     <= '0;
            prep_pend_q  <= 1'b0;
            prep_req_q   <= 1'b0;
            prep_done_q  <= 1'b0;
            calib_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            settle_q     <= settle_d;
            prep_pend_q  <= prep_pend_d;
            prep_req_q   <= prep_req;
            // Registered from next state so the pulses line up with the state they describe.
            prep_done_q  <= (state_d == StDone);
            calib_done_q <= calib_done_d;
            busy_q       <= state_is_busy(state_d);
        end
    end

    assign servo_pos  = pos_q;
    assign prep_done  = prep_done_q;
    assign calib_done = calib_done_q;
    assign busy       = busy_q;
    assign db_estado  = state_q;

endmodule
